clock_mode_ctrl: RTL and testbench

//  Mode sequencer for the mm:ss clock: drives the EN/INC/CLR controls of the seconds and

---
 rtl/clock_mode_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the mm:ss clock: RUN/STOP/SET_MIN/SET_SEC, blink gating and UP-key handling.
// Define CLOCK_AUTO_REPEAT_EN to build the UP-key auto-repeat counter.
module clock_mode_ctrl #(
  parameter int unsigned RepeatDly  = 4,
  parameter int unsigned RepeatRate = 2,
  parameter int unsigned BlinkHalf  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_1hz_i,
  input  logic       tick_8hz_i,
  input  logic       mode_i,
  input  logic       clr_i,
  input  logic       up_i,
  input  logic       ca_sec_i,
  output logic       sec_en_o,
  output logic       sec_inc_o,
  output logic       sec_clr_o,
  output logic       min_en_o,
  output logic       min_inc_o,
  output logic       min_clr_o,
  output logic       disp_sec_o,
  output logic       disp_min_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StStop   = 2'b01,
    StSetMin = 2'b10,
    StSetSec = 2'b11
  } state_e;

  localparam logic [7:0] BlinkHalfW = 8'(BlinkHalf);

  state_e     state_q, state_d;
  logic       sec_en_q, sec_en_d, sec_inc_q, sec_inc_d, sec_clr_q, sec_clr_d;
  logic       min_en_q, min_en_d, min_inc_q, min_inc_d, min_clr_q, min_clr_d;
  logic       disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic       up_prev_q;
  logic [7:0] blink_cnt_q, blink_cnt_d, blink_nxt;
  logic       in_set, up_rise, rpt_fire, inc_req;

  assign in_set  = (state_q == StSetMin) || (state_q == StSetSec);
  assign up_rise = up_i & ~up_prev_q;

`ifdef CLOCK_AUTO_REPEAT_EN
  localparam logic [8:0] RptFirst = 9'(RepeatDly);
  localparam logic [8:0] RptNext  = 9'(RepeatDly + RepeatRate);

  logic [7:0] rpt_cnt_q, rpt_cnt_d;
  logic [8:0] rpt_inc;

  // After the first repeat the counter is parked at RepeatDly so later pulses land every RepeatRate.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    rpt_inc   = {1'b0, rpt_cnt_q} + 9'd1;
    if (!in_set || !up_i || mode_i) begin
      rpt_cnt_d = '0;
    end else if (tick_8hz_i) begin
      if (rpt_inc == RptFirst) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = rpt_inc[7:0];
      end else if (rpt_inc == RptNext) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RptFirst[7:0];
      end else if (rpt_cnt_q != 8'hff) begin
        rpt_cnt_d = rpt_inc[7:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rpt_cnt_q <= '0;
    else         rpt_cnt_q <= rpt_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{RepeatDly[7:0], RepeatRate[7:0]};
  assign rpt_fire   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sec_en_d    = 1'b0;
    sec_inc_d   = 1'b0;
    sec_clr_d   = 1'b0;
    min_en_d    = 1'b0;
    min_inc_d   = 1'b0;
    min_clr_d   = 1'b0;
    disp_sec_d  = disp_sec_q;
    disp_min_d  = disp_min_q;
    blink_cnt_d = blink_cnt_q;
    blink_nxt   = (blink_cnt_q == 8'hff) ? 8'hff : blink_cnt_q + 8'd1;
    inc_req     = (up_rise | rpt_fire) & ~mode_i;

    unique case (state_q)
      StRun: begin
        sec_en_d = tick_1hz_i;
        min_en_d = ca_sec_i;
      end
      StSetMin: min_inc_d = inc_req;
      StSetSec: sec_inc_d = inc_req;
      default: ;
    endcase

    if (state_q != StRun) begin
      sec_clr_d = clr_i;
      min_clr_d = clr_i;
    end

    if (in_set && tick_8hz_i) begin
      if (blink_nxt == BlinkHalfW) begin
        blink_cnt_d = '0;
        if (state_q == StSetMin) disp_min_d = ~disp_min_q;
        else                     disp_sec_d = ~disp_sec_q;
      end else begin
        blink_cnt_d = blink_nxt;
      end
    end

    // Mode order matches the binary encoding, so advancing is a wrapping increment.
    if (mode_i) begin
      state_d     = state_e'(state_q + 2'd1);
      blink_cnt_d = '0;
      disp_sec_d  = 1'b1;
      disp_min_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      sec_en_q    <= 1'b0;
      sec_inc_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      min_en_q    <= 1'b0;
      min_inc_q   <= 1'b0;
      min_clr_q   <= 1'b0;
      disp_sec_q  <= 1'b1;
      disp_min_q  <= 1'b1;
      blink_cnt_q <= '0;
      up_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sec_en_q    <= sec_en_d;
      sec_inc_q   <= sec_inc_d;
      sec_clr_q   <= sec_clr_d;
      min_en_q    <= min_en_d;
      min_inc_q   <= min_inc_d;
      min_clr_q   <= min_clr_d;
      disp_sec_q  <= disp_sec_d;
      disp_min_q  <= disp_min_d;
      blink_cnt_q <= blink_cnt_d;
      up_prev_q   <= up_i;
    end
  end

  assign sec_en_o   = sec_en_q;
  assign sec_inc_o  = sec_inc_q;
  assign sec_clr_o  = sec_clr_q;
  assign min_en_o   = min_en_q;
  assign min_inc_o  = min_inc_q;
  assign min_clr_o  = min_clr_q;
  assign disp_sec_o = disp_sec_q;
  assign disp_min_o = disp_min_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: stimulus queues expected control pulses, a monitor checks them.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, tick_8hz = 1'b0, mode = 1'b0, clr = 1'b0, up = 1'b0;
  logic       ca_sec = 1'b0;
  logic       sec_en, sec_inc, sec_clr, min_en, min_inc, min_clr, disp_sec, disp_min;
  logic [1:0] state;

  typedef struct {
    logic [5:0] ev;
    int         cyc;
  } ev_t;

  ev_t  evq[$];
  ev_t  exp_e;
  ev_t  got_e;
  logic [5:0] act;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Pulse vector order: {sec_en, sec_inc, sec_clr, min_en, min_inc, min_clr}
  localparam logic [5:0] EvSecEn  = 6'b100000;
  localparam logic [5:0] EvSecInc = 6'b010000;
  localparam logic [5:0] EvClr    = 6'b001001;
  localparam logic [5:0] EvMinEn  = 6'b000100;
  localparam logic [5:0] EvMinInc = 6'b000010;

  clock_mode_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tick_1hz_i (tick_1hz),
    .tick_8hz_i (tick_8hz),
    .mode_i     (mode),
    .clr_i      (clr),
    .up_i       (up),
    .ca_sec_i   (ca_sec),
    .sec_en_o   (sec_en),
    .sec_inc_o  (sec_inc),
    .sec_clr_o  (sec_clr),
    .min_en_o   (min_en),
    .min_inc_o  (min_inc),
    .min_clr_o  (min_clr),
    .disp_sec_o (disp_sec),
    .disp_min_o (disp_min),
    .state_o    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with any control pulse must match the head of the queue.
  always @(negedge clk) begin
    act = {sec_en, sec_inc, sec_clr, min_en, min_inc, min_clr};
    if (act != 6'b0) begin
      n_cmp++;
      if (evq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d: got %b required none", cyc, act);
      end else begin
        got_e = evq.pop_front();
        if (got_e.ev !== act || got_e.cyc != cyc) begin
          n_bad++;
          $display("FAIL pulse: got %b at cyc %0d, required %b at cyc %0d",
                   act, cyc, got_e.ev, got_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic drive(input logic t1, input logic t8, input logic md, input logic cl,
                       input logic ca, input logic [5:0] exp_ev);
    tick_1hz = t1;
    tick_8hz = t8;
    mode     = md;
    clr      = cl;
    ca_sec   = ca;
    if (exp_ev != 6'b0) begin
      exp_e.ev  = exp_ev;
      exp_e.cyc = cyc + 1;
      evq.push_back(exp_e);
    end
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    tick_8hz = 1'b0;
    mode     = 1'b0;
    clr      = 1'b0;
    ca_sec   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0);
  endtask

  initial begin
    // 1: reset with UP held, no INC after release
    up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_disp", 32'({disp_min, disp_sec}), 32'h3);
    rst_n = 1'b1;
    idle(20);
    check("post_reset_state", 32'(state), 32'd0);
    up = 1'b0;
    idle(1);

    // 2: RUN, 60 seconds ticks with carry on the last
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EvSecEn);
      drive(1'b0, 1'b0, 1'b0, 1'b0, i == 59, (i == 59) ? EvMinEn : 6'b0);
    end

    // 3: to SET_MIN, UP tap, blink
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    check("state_stop", 32'(state), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    check("state_set_min", 32'(state), 32'd2);
    check("set_min_disp", 32'({disp_min, disp_sec}), 32'h3);
    up = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EvMinInc);
    up = 1'b0;
    idle(1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0);
      check($sformatf("blink_min_t%0d", k), 32'(disp_min), (k >= 4 && k < 8) ? 32'd0 : 32'd1);
      check($sformatf("blink_sec_t%0d", k), 32'(disp_sec), 32'd1);
      idle(1);
    end

    // 5: SET_SEC, UP held for 10 eighth-second ticks
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    check("state_set_sec", 32'(state), 32'd3);
    check("set_sec_disp", 32'({disp_min, disp_sec}), 32'h3);
    up = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EvSecInc);
    for (int k = 1; k <= 10; k++) begin
`ifdef CLOCK_AUTO_REPEAT_EN
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (k >= 4 && k % 2 == 0) ? EvSecInc : 6'b0);
`else
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0);
`endif
      idle(1);
    end
    up = 1'b0;
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0);
    check("blink_sec_hidden", 32'({disp_min, disp_sec}), 32'h2);

    // 4: MODE and CLR together in SET_SEC
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, EvClr);
    check("mode_clr_state", 32'(state), 32'd0);
    check("mode_clr_disp", 32'({disp_min, disp_sec}), 32'h3);

    // 6: RUN ignores CLR and UP, seconds still follow the 1 Hz tick
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0);
    up = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EvSecEn);
    up = 1'b0;
    idle(1);
    check("run_state_kept", 32'(state), 32'd0);

    // MODE+CLR in RUN drops the clear; MODE+UP drops the edge
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0);
    check("run_mode_clr_state", 32'(state), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    up = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    check("mode_up_state", 32'(state), 32'd3);
    up = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0);
    check("wrap_state", 32'(state), 32'd0);

    idle(3);
    check("queue_drained", 32'(evq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
